// File: rtl/wb_stage.sv
// Writeback stage: registers ALU results, waits for load data, formats
// load bytes/halfwords and drives the register file write port.
module wb_stage #(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic            mem_is_load,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_addr_lo,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [4:0]      rd_sel,
    output logic            reg_write,
    output logic [XLEN-1:0] wb_data,
    output logic            load_pending,
    output logic            load_fault,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic            ld_we_q, ld_we_d;
    logic [2:0]      ld_f3_q, ld_f3_d;
    logic [1:0]      ld_lo_q, ld_lo_d;
    logic            reg_write_q, reg_write_d;
    logic [4:0]      rd_sel_q, rd_sel_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            load_fault_q, load_fault_d;

    logic [7:0]      lane [4];
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] fmt_data;
    logic            fmt_ok;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = dmem_rdata[8*gi +: 8];
    end

    assign byte_sel = lane[ld_lo_q];
    // Halfword selection uses only addr_lo[1]; misaligned low bit is ignored.
    assign half_sel = ld_lo_q[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

    always_comb begin
        fmt_data = dmem_rdata;
        fmt_ok   = 1'b1;
        case (ld_f3_q)
            3'b000:  fmt_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  fmt_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b010:  fmt_data = dmem_rdata;
            3'b100:  fmt_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  fmt_data = {{(XLEN-16){1'b0}}, half_sel};
            default: fmt_ok   = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ld_rd_d      = ld_rd_q;
        ld_we_d      = ld_we_q;
        ld_f3_d      = ld_f3_q;
        ld_lo_d      = ld_lo_q;
        reg_write_d  = 1'b0;
        rd_sel_d     = rd_sel_q;
        wb_data_d    = wb_data_q;
        load_fault_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    if (mem_is_load) begin
                        ld_rd_d = mem_rd;
                        ld_we_d = mem_reg_write;
                        ld_f3_d = mem_funct3;
                        ld_lo_d = mem_addr_lo;
                        cnt_d   = 8'd0;
                        state_d = S_WAIT;
                    end else if (mem_reg_write && (mem_rd != 5'd0)) begin
                        reg_write_d = 1'b1;
                        rd_sel_d    = mem_rd;
                        wb_data_d   = mem_alu_result;
                    end
                end
            end
            S_WAIT: begin
                // Returned data takes priority over a timeout on the same cycle.
                if (dmem_rvalid) begin
                    state_d = S_IDLE;
                    if (!fmt_ok) begin
                        load_fault_d = 1'b1;
                    end else if (ld_we_q && (ld_rd_q != 5'd0)) begin
                        reg_write_d = 1'b1;
                        rd_sel_d    = ld_rd_q;
                        wb_data_d   = fmt_data;
                    end
                end else if (cnt_q == 8'(LOAD_TIMEOUT - 1)) begin
                    load_fault_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            ld_rd_q      <= 5'd0;
            ld_we_q      <= 1'b0;
            ld_f3_q      <= 3'd0;
            ld_lo_q      <= 2'd0;
            reg_write_q  <= 1'b0;
            rd_sel_q     <= 5'd0;
            wb_data_q    <= '0;
            load_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ld_rd_q      <= ld_rd_d;
            ld_we_q      <= ld_we_d;
            ld_f3_q      <= ld_f3_d;
            ld_lo_q      <= ld_lo_d;
            reg_write_q  <= reg_write_d;
            rd_sel_q     <= rd_sel_d;
            wb_data_q    <= wb_data_d;
            load_fault_q <= load_fault_d;
        end
    end

    assign mem_ready    = (state_q == S_IDLE) && !reset;
    assign load_pending = (state_q == S_WAIT);
    assign reg_write    = reg_write_q;
    assign rd_sel       = rd_sel_q;
    assign wb_data      = wb_data_q;
    assign load_fault   = load_fault_q;
    assign fwd_valid    = reg_write_q;
    assign fwd_rd       = rd_sel_q;
    assign fwd_data     = wb_data_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus queues expected writes and faults,
// a negedge monitor pops and compares whenever the DUT retires or faults.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_is_load;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu_result;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  rd_sel;
    logic        reg_write;
    logic [31:0] wb_data;
    logic        load_pending;
    logic        load_fault;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    wb_stage #(.XLEN(32), .LOAD_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_is_load(mem_is_load), .mem_funct3(mem_funct3),
        .mem_addr_lo(mem_addr_lo), .mem_alu_result(mem_alu_result),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rd_sel(rd_sel), .reg_write(reg_write), .wb_data(wb_data),
        .load_pending(load_pending), .load_fault(load_fault),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  fault_exp = 0;
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: every write and every fault pulse must have been predicted.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (reg_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: rd=%0d data=0x%08h, required none", rd_sel, wb_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_rd", {27'd0, rd_sel}, {27'd0, e.rd});
                    check("wr_data", wb_data, e.data);
                    check("fwd_valid", {31'd0, fwd_valid}, 32'd1);
                    check("fwd_rd", {27'd0, fwd_rd}, {27'd0, e.rd});
                    check("fwd_data", fwd_data, e.data);
                end
            end
            if (load_fault === 1'b1) begin
                checks++;
                if (fault_exp == 0) begin
                    errors++;
                    $display("FAIL unexpected_fault: load_fault=1, required 0");
                end else begin
                    fault_exp--;
                    $display("ok   load_fault pulse");
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_alu(input logic [4:0] rd, input logic we, input logic [31:0] data);
        check("ready_alu", {31'd0, mem_ready}, 32'd1);
        mem_valid = 1'b1; mem_is_load = 1'b0; mem_rd = rd;
        mem_reg_write = we; mem_alu_result = data;
        if (we && rd != 5'd0) exp_q.push_back('{rd: rd, data: data});
        tick();
        mem_valid = 1'b0;
    endtask

    task automatic send_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
        check("ready_load", {31'd0, mem_ready}, 32'd1);
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_rd = rd;
        mem_reg_write = 1'b1; mem_funct3 = f3; mem_addr_lo = lo;
        tick();
        mem_valid = 1'b0; mem_is_load = 1'b0;
    endtask

    // rvalid arrives on the n-th cycle after the accepting edge.
    task automatic return_data(input int n, input logic [31:0] data);
        for (int i = 1; i < n; i++) begin
            check("wait_ready", {31'd0, mem_ready}, 32'd0);
            check("wait_pending", {31'd0, load_pending}, 32'd1);
            tick();
        end
        dmem_rvalid = 1'b1; dmem_rdata = data;
        tick();
        dmem_rvalid = 1'b0;
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                        input int n, input logic [31:0] raw, input logic [31:0] expv);
        send_load(rd, f3, lo);
        exp_q.push_back('{rd: rd, data: expv});
        return_data(n, raw);
    endtask

    initial begin
        reset = 1'b1; mem_valid = 1'b0; mem_rd = 5'd0; mem_reg_write = 1'b0;
        mem_is_load = 1'b0; mem_funct3 = 3'd0; mem_addr_lo = 2'd0;
        mem_alu_result = 32'd0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        tick(); tick();
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_reg_write", {31'd0, reg_write}, 32'd0);
        check("rst_rd_sel", {27'd0, rd_sel}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_fault", {31'd0, load_fault}, 32'd0);
        check("rst_pending", {31'd0, load_pending}, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, mem_ready}, 32'd1);

        // Back-to-back ALU results, then rd=0 and no-write ops
        send_alu(5'd5, 1'b1, 32'h0000_1234);
        send_alu(5'd6, 1'b1, 32'hFFFF_0000);
        send_alu(5'd0, 1'b1, 32'hDEAD_0000);
        send_alu(5'd7, 1'b0, 32'hBEEF_0000);
        check("hold_rd_sel", {27'd0, rd_sel}, 32'd6);
        check("hold_wb_data", wb_data, 32'hFFFF_0000);

        // Byte/half/word loads
        load(5'd8,  3'b000, 2'd3, 3, 32'h80FF_7F01, 32'hFFFF_FF80);
        load(5'd9,  3'b100, 2'd3, 3, 32'h80FF_7F01, 32'h0000_0080);
        load(5'd10, 3'b000, 2'd1, 1, 32'h80FF_7F01, 32'h0000_007F);
        load(5'd11, 3'b001, 2'd2, 2, 32'h8001_7FFE, 32'hFFFF_8001);
        load(5'd12, 3'b101, 2'd2, 1, 32'h8001_7FFE, 32'h0000_8001);
        load(5'd13, 3'b001, 2'd0, 1, 32'h8001_7FFE, 32'h0000_7FFE);
        load(5'd14, 3'b001, 2'd3, 1, 32'h8001_7FFE, 32'hFFFF_8001);
        // rvalid on the last permitted cycle: data wins over timeout
        load(5'd15, 3'b010, 2'd0, 4, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        send_alu(5'd16, 1'b1, 32'h0000_0042);

        // Timeout with a late rvalid
        send_load(5'd17, 3'b010, 2'd0);
        fault_exp++;
        for (int i = 0; i < 4; i++) begin
            check("to_pending", {31'd0, load_pending}, 32'd1);
            tick();
        end
        check("to_fault", {31'd0, load_fault}, 32'd1);
        check("to_ready", {31'd0, mem_ready}, 32'd1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
        tick();
        dmem_rvalid = 1'b0;
        check("to_fault_clr", {31'd0, load_fault}, 32'd0);

        // Illegal funct3
        send_load(5'd18, 3'b011, 2'd0);
        fault_exp++;
        return_data(1, 32'h2222_2222);
        send_load(5'd18, 3'b110, 2'd0);
        fault_exp++;
        return_data(2, 32'h2222_2222);

        // Reset while waiting abandons the load
        send_load(5'd19, 3'b010, 2'd0);
        tick();
        reset = 1'b1;
        #1;
        check("midrst_ready", {31'd0, mem_ready}, 32'd0);
        tick();
        check("midrst_ready2", {31'd0, mem_ready}, 32'd0);
        check("midrst_pending", {31'd0, load_pending}, 32'd0);
        reset = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h3333_3333;
        #1;
        check("midrst_ready_rel", {31'd0, mem_ready}, 32'd1);
        check("midrst_rd_sel", {27'd0, rd_sel}, 32'd0);
        check("midrst_wb_data", wb_data, 32'd0);
        check("midrst_reg_write", {31'd0, reg_write}, 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        send_alu(5'd20, 1'b1, 32'hCAFE_F00D);
        tick(); tick();

        check("exp_q_empty", exp_q.size(), 32'd0);
        check("faults_seen", fault_exp, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
